// File: rtl/sseg_scan_controller.sv
// ---------------------------------------------------------------------------
// sseg_scan_controller
//
// Time-multiplexes one shared combinational hex-to-7-segment decoder across
// NUM_DIGITS common-anode digits. Each digit slot is BLANK_CYCLES clocks with
// every anode off, followed by DWELL_CYCLES clocks with the digit lit. The
// displayed value is double-buffered, so host updates only take effect on
// frame boundaries.
//
// Ports
//   clk          system clock
//   reset_n      synchronous reset, active-low
//   load         one-cycle strobe: capture value_in/dp_in/digit_en_in
//   value_in     hex digits, nibble k = digit k (digit 0 = rightmost)
//   dp_in        decimal-point enables, 1 = lit
//   digit_en_in  per-digit enable, 1 = digit may light
//   lz_suppress  live leading-zero suppression enable
//   bin_out      nibble to the shared decoder (shadow nibble of current idx)
//   sseg_in      decoder result, active-low, bit 7 ignored
//   sseg_out     registered segments, active-low, bit 7 = DP
//   an_out       registered anodes, active-low
//   load_ack     one-cycle pulse when staging is committed to shadow
//   frame_tick   one-cycle pulse at the start of every frame
//
// Handshake: load has no ready. Any cycle with load=1 overwrites staging and
// marks it pending. Pending staging is committed on the frame-boundary edge
// (leaving SHOW of the last digit), and load_ack pulses with frame_tick on
// the following cycle. A load on the boundary cycle itself stays pending for
// the next boundary, because the commit uses the staging contents from
// before that edge.
// ---------------------------------------------------------------------------
module sseg_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en_in,
    input  logic                    lz_suppress,
    output logic [3:0]              bin_out,
    input  logic [7:0]              sseg_in,
    output logic [7:0]              sseg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    load_ack,
    output logic                    frame_tick
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // All scan-sequencer state in one struct so checkers can bind to it.
    typedef struct packed {
        state_t        state;
        logic [IW-1:0] idx;
        logic [CW-1:0] cnt;
        logic          pending;
    } scan_t;

    scan_t scan;

    logic [4*NUM_DIGITS-1:0] shadow_val, stg_val;
    logic [NUM_DIGITS-1:0]   shadow_dp,  stg_dp;
    logic [NUM_DIGITS-1:0]   shadow_en,  stg_en;

    logic                  boundary;
    logic                  upper_zero;
    logic                  visible;
    logic [NUM_DIGITS-1:0] an_onehot;
    logic                  unused_dp_bit;

    // The decoder always drives its DP bit high; the real DP comes from shadow_dp.
    assign unused_dp_bit = sseg_in[7];

    assign bin_out  = shadow_val[{scan.idx, 2'b00} +: 4];
    assign boundary = (scan.state == ST_SHOW) && (scan.cnt == DWELL_LAST) &&
                      (scan.idx == IDX_LAST);

    // Leading-zero suppression: digit idx is dark when it and every digit
    // above it hold zero. Digit 0 always shows so a zero value reads "0".
    always_comb begin
        upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((k >= int'(scan.idx)) && (shadow_val[4*k +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
        visible = shadow_en[scan.idx] &&
                  !(lz_suppress && (scan.idx != '0) && upper_zero);
    end

    always_comb begin
        an_onehot           = '1;
        an_onehot[scan.idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scan       <= '{state: ST_BLANK, idx: '0, cnt: '0, pending: 1'b0};
            shadow_val <= '0;
            shadow_dp  <= '0;
            shadow_en  <= '0;
            stg_val    <= '0;
            stg_dp     <= '0;
            stg_en     <= '0;
            an_out     <= '1;
            sseg_out   <= 8'hFF;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= boundary;
            load_ack   <= boundary && scan.pending;

            if (boundary && scan.pending) begin
                shadow_val   <= stg_val;
                shadow_dp    <= stg_dp;
                shadow_en    <= stg_en;
                scan.pending <= 1'b0;
            end

            // Placed after the commit so a boundary-cycle load keeps pending set.
            if (load) begin
                stg_val      <= value_in;
                stg_dp       <= dp_in;
                stg_en       <= digit_en_in;
                scan.pending <= 1'b1;
            end

            case (scan.state)
                ST_BLANK: begin
                    if (scan.cnt == BLANK_LAST) begin
                        scan.state <= ST_SHOW;
                        scan.cnt   <= '0;
                    end else begin
                        scan.cnt <= scan.cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (scan.cnt == DWELL_LAST) begin
                        scan.state <= ST_BLANK;
                        scan.cnt   <= '0;
                        // idx advances on entry to BLANK so bin_out settles before SHOW.
                        scan.idx   <= (scan.idx == IDX_LAST) ? '0 : scan.idx + 1'b1;
                    end else begin
                        scan.cnt <= scan.cnt + 1'b1;
                    end
                end
                default: begin
                    scan.state <= ST_BLANK;
                    scan.cnt   <= '0;
                end
            endcase

            if ((scan.state == ST_SHOW) && visible) begin
                an_out   <= an_onehot;
                sseg_out <= {~shadow_dp[scan.idx], sseg_in[6:0]};
            end else begin
                an_out   <= '1;
                sseg_out <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_sseg_scan_controller
//
// Bench for sseg_scan_controller with NUM_DIGITS=4, DWELL=4, BLANK=2.
// A position-in-frame reference model predicts every output each cycle; the
// prediction is queued before the clock edge and compared after it.
// Table entries additionally check which digits lit during one whole frame.
// ---------------------------------------------------------------------------
module tb_sseg_scan_controller;

    localparam int N    = 4;
    localparam int DW   = 4;
    localparam int BL   = 2;
    localparam int SLOT = DW + BL;
    localparam int FL   = N * SLOT;
    localparam int W    = 18;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            load = 1'b0;
    logic [4*N-1:0]  value_in = '0;
    logic [N-1:0]    dp_in = '0;
    logic [N-1:0]    digit_en_in = '0;
    logic            lz_suppress = 1'b0;
    logic [3:0]      bin_out;
    logic [7:0]      sseg_in;
    logic [7:0]      sseg_out;
    logic [N-1:0]    an_out;
    logic            load_ack;
    logic            frame_tick;

    sseg_scan_controller #(
        .NUM_DIGITS  (N),
        .DWELL_CYCLES(DW),
        .BLANK_CYCLES(BL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .digit_en_in(digit_en_in),
        .lz_suppress(lz_suppress),
        .bin_out    (bin_out),
        .sseg_in    (sseg_in),
        .sseg_out   (sseg_out),
        .an_out     (an_out),
        .load_ack   (load_ack),
        .frame_tick (frame_tick)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- board decoder (active-low, gfedcba) ----------------
    function automatic logic [6:0] seg7(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'hC0; 4'h1: s = 8'hF9; 4'h2: s = 8'hA4; 4'h3: s = 8'hB0;
            4'h4: s = 8'h99; 4'h5: s = 8'h92; 4'h6: s = 8'h82; 4'h7: s = 8'hF8;
            4'h8: s = 8'h80; 4'h9: s = 8'h90; 4'hA: s = 8'h88; 4'hB: s = 8'h83;
            4'hC: s = 8'hC6; 4'hD: s = 8'hA1; 4'hE: s = 8'h86; default: s = 8'h8E;
        endcase
        return s[6:0];
    endfunction

    assign sseg_in = {1'b1, seg7(bin_out)};

    // ---------------- reference model ----------------
    int             m_pos = 0;
    logic [4*N-1:0] m_sh_v = '0, m_st_v = '0;
    logic [N-1:0]   m_sh_dp = '0, m_st_dp = '0;
    logic [N-1:0]   m_sh_en = '0, m_st_en = '0;
    logic           m_pending = 1'b0;

    function automatic logic [3:0] nib(input logic [4*N-1:0] v, input int s);
        logic [4*N-1:0] t;
        t = v >> (4 * s);
        return t[3:0];
    endfunction

    function automatic logic vis(input int s);
        logic [4*N-1:0] upper;
        upper = m_sh_v >> (4 * s);
        return m_sh_en[s] && !(lz_suppress && (s != 0) && (upper == '0));
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    logic [N-1:0] lit = '0;
    int           acks = 0;
    int           ticks = 0;
    int           cyc = 0;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // One clock: predict, push, clock, pop and compare.
    task automatic tick();
        logic [N-1:0] an_e;
        logic [7:0]   ss_e;
        logic         ack_e;
        logic         bnd;
        logic [3:0]   bin_e;
        logic [W-1:0] got;
        logic [W-1:0] e;
        int           slot;
        an_e  = '1;
        ss_e  = 8'hFF;
        ack_e = 1'b0;
        bnd   = 1'b0;
        if (!reset_n) begin
            m_pos = 0; m_pending = 1'b0;
            m_sh_v = '0; m_sh_dp = '0; m_sh_en = '0;
            m_st_v = '0; m_st_dp = '0; m_st_en = '0;
        end else begin
            slot = m_pos / SLOT;
            if (((m_pos % SLOT) >= BL) && vis(slot)) begin
                an_e[slot] = 1'b0;
                ss_e = {~m_sh_dp[slot], seg7(nib(m_sh_v, slot))};
            end
            bnd   = (m_pos == FL - 1);
            ack_e = bnd && m_pending;
            if (ack_e) begin
                m_sh_v = m_st_v; m_sh_dp = m_st_dp; m_sh_en = m_st_en;
                m_pending = 1'b0;
            end
            if (load) begin
                m_st_v = value_in; m_st_dp = dp_in; m_st_en = digit_en_in;
                m_pending = 1'b1;
            end
            m_pos = (m_pos + 1) % FL;
        end
        bin_e = nib(m_sh_v, m_pos / SLOT);
        exp_q.push_back({an_e, ss_e, ack_e, bnd, bin_e});
        @(posedge clk);
        #1;
        cyc++;
        got = {an_out, sseg_out, load_ack, frame_tick, bin_out};
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL outputs(an,sseg,ack,tick,bin): got %h,%h,%b,%b,%h expected %h,%h,%b,%b,%h (cycle %0d)",
                     got[17:14], got[13:6], got[5], got[4], got[3:0],
                     e[17:14], e[13:6], e[5], e[4], e[3:0], cyc);
        end
        lit   = lit | ~an_out;
        acks  = acks + int'(load_ack);
        ticks = ticks + int'(frame_tick);
    endtask

    task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] dp,
                           input logic [N-1:0] en);
        value_in = v; dp_in = dp; digit_en_in = en; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * FL && !seen; i++) begin
            tick();
            seen = load_ack;
        end
        check(name, int'(seen), 1);
    endtask

    // Advance until the model's next edge is at frame position p.
    task automatic goto_pos(input int p);
        for (int i = 0; i < FL && m_pos != p; i++) tick();
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [4*N-1:0] value;
        logic [N-1:0]   dp;
        logic [N-1:0]   en;
        logic           lz;
        logic [N-1:0]   exp_lit;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int cnt;
        logic seen;

        vecs[0] = '{16'h12AF, 4'b0100, 4'hF,    1'b0, 4'b1111};
        vecs[1] = '{16'h0050, 4'b0000, 4'hF,    1'b1, 4'b0011};
        vecs[2] = '{16'h0000, 4'b0001, 4'hF,    1'b1, 4'b0001};
        vecs[3] = '{16'h0000, 4'b1000, 4'hF,    1'b0, 4'b1111};
        vecs[4] = '{16'h1234, 4'b1111, 4'b1010, 1'b0, 4'b1010};
        vecs[5] = '{16'h0100, 4'b0010, 4'hF,    1'b1, 4'b0111};
        vecs[6] = '{16'h0005, 4'b0000, 4'b1110, 1'b1, 4'b0000};

        // Reset held for three clocks.
        reset_n = 1'b0;
        repeat (3) tick();
        check("reset_an", int'(an_out), 'hF);
        check("reset_sseg", int'(sseg_out), 'hFF);
        check("reset_bin", int'(bin_out), 0);

        // First frame_tick comes FL clocks after release.
        reset_n = 1'b1;
        cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 2 * FL && !seen; i++) begin
            tick();
            cnt++;
            seen = frame_tick;
        end
        check("first_frame_tick_latency", cnt, FL);

        // Table-driven: load, wait for commit, observe one full frame.
        foreach (vecs[i]) begin
            lz_suppress = vecs[i].lz;
            do_load(vecs[i].value, vecs[i].dp, vecs[i].en);
            wait_ack($sformatf("vec%0d_ack", i));
            check($sformatf("vec%0d_ack_with_tick", i), int'(frame_tick), 1);
            lit = '0; acks = 0; ticks = 0;
            repeat (FL) tick();
            check($sformatf("vec%0d_lit_mask", i), int'(lit), int'(vecs[i].exp_lit));
            check($sformatf("vec%0d_ticks", i), ticks, 1);
        end
        lz_suppress = 1'b0;

        // Two loads in one frame: last wins, single ack.
        goto_pos(1);
        do_load(16'h1111, 4'h0, 4'hF);
        repeat (5) tick();
        do_load(16'h2222, 4'h0, 4'hF);
        wait_ack("double_load_ack");
        check("double_load_value", int'(bin_out), 2);
        acks = 0;
        repeat (FL) tick();
        check("double_load_single_ack", acks, 0);

        // Load on the boundary cycle while earlier data is pending.
        goto_pos(4);
        do_load(16'h3333, 4'h0, 4'hF);
        goto_pos(FL - 1);
        do_load(16'h4444, 4'h0, 4'hF);
        check("boundary_ack_old", int'(load_ack), 1);
        check("boundary_commit_old", int'(bin_out), 3);
        repeat (FL) tick();
        check("boundary_next_tick", int'(frame_tick), 1);
        check("boundary_next_ack", int'(load_ack), 1);
        check("boundary_commit_new", int'(bin_out), 4);

        // Reset during SHOW with a load pending: load is discarded.
        goto_pos(2);
        do_load(16'h5555, 4'hF, 4'hF);
        goto_pos(9);
        reset_n = 1'b0;
        tick();
        check("midreset_an", int'(an_out), 'hF);
        check("midreset_sseg", int'(sseg_out), 'hFF);
        check("midreset_ack", int'(load_ack), 0);
        reset_n = 1'b1;
        acks = 0; ticks = 0;
        repeat (3 * FL) tick();
        check("midreset_no_ack", acks, 0);
        check("midreset_ticks", ticks, 3);

        // Random loads at random points in the frame.
        for (int r = 0; r < 6; r++) begin
            lz_suppress = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, FL - 1)) tick();
            do_load(16'($urandom_range(0, 16'hFFFF)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)));
            repeat (2 * FL) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
